// File: rtl/nt_obs_pkg.sv
// Shared types and default parameters for the node observation compactor.
package nt_obs_pkg;

  localparam int          DEF_SIG_W = 16;
  localparam int          DEF_CNT_W = 16;
  localparam logic [15:0] DEF_POLY  = 16'hB400;
  localparam logic [15:0] DEF_SEED  = 16'hFFFF;

  // Encoding chosen so busy and done are single state flops (bit 0 / bit 1).
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } obs_state_t;

endpackage

// File: rtl/nt_misr.sv
// Single-input Galois MISR (right shift); reloads SEED on load, steps on en.
module nt_misr #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'hB400,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur, input logic bit_in);
    return (cur >> 1) ^ ((cur[0] ^ bit_in) ? POLY : {SIG_W{1'b0}});
  endfunction

  // Signature register: seed on reset/load, one compaction step per enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/nt_node_obs_compactor.sv
// Observation window controller: captures win_len samples of obs_in into a
// MISR signature plus ones/toggle counts, then holds results until ack.
module nt_node_obs_compactor
  import nt_obs_pkg::*;
#(
  parameter int               SIG_W = DEF_SIG_W,
  parameter int               CNT_W = DEF_CNT_W,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             obs_in,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  output logic             busy,
  output logic             done,
  input  logic             ack,
  output logic [SIG_W-1:0] sig_out,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  obs_state_t       state_r;
  logic [CNT_W-1:0] remaining_r;
  logic [CNT_W-1:0] ones_r;
  logic [CNT_W-1:0] toggles_r;
  logic             prev_r;
  logic             misr_load_s;
  logic             misr_en_s;

  // MISR control: seed on window acceptance, step on every RUN edge.
  always_comb begin
    misr_load_s = 1'b0;
    misr_en_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      misr_load_s = start && (win_len != CNT_ZERO);
    end else if (state_r == ST_RUN) begin
      misr_en_s = 1'b1;
    end else begin
      misr_load_s = 1'b0;
      misr_en_s   = 1'b0;
    end
  end

  nt_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (I1470_clk),
    .rst_n (I1477_rst),
    .load  (misr_load_s),
    .en    (misr_en_s),
    .din   (obs_in),
    .sig   (sig_out)
  );

  // Window FSM and sample counters.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      state_r     <= ST_IDLE;
      remaining_r <= CNT_ZERO;
      ones_r      <= CNT_ZERO;
      toggles_r   <= CNT_ZERO;
      prev_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (win_len != CNT_ZERO)) begin
            state_r     <= ST_RUN;
            remaining_r <= win_len;
            ones_r      <= CNT_ZERO;
            toggles_r   <= CNT_ZERO;
            prev_r      <= 1'b0;
          end
        end
        ST_RUN: begin
          ones_r      <= ones_r + {{(CNT_W-1){1'b0}}, obs_in};
          toggles_r   <= (obs_in != prev_r) ? (toggles_r + CNT_ONE) : toggles_r;
          prev_r      <= obs_in;
          remaining_r <= remaining_r - CNT_ONE;
          if (remaining_r == CNT_ONE) begin
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ack) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = state_r[0];
  assign done       = state_r[1];
  assign ones_cnt   = ones_r;
  assign toggle_cnt = toggles_r;

endmodule

// File: doc/nt_node_obs_compactor.md
NT_NODE_OBS_COMPACTOR -- requirements
Module: nt_node_obs_compactor

Interface
REQ-001 Parameter SIG_W, default 16, is the signature register width.
REQ-002 Parameter CNT_W, default 16, is the width of the window length and of both counters.
REQ-003 Parameter POLY, default 16'hB400, is the MISR feedback mask (x^16+x^14+x^13+x^11+1, Galois, right-shift).
REQ-004 Parameter SEED, default 16'hFFFF, is the signature value loaded at window start.
REQ-005 The block SHALL have these ports (clock and reset first):
- I1470_clk, input, 1: the single clock; all state updates on the rising edge.
- I1477_rst, input, 1: asynchronous, active-low reset.
- obs_in, input, 1: observed node output from the upstream subcircuit, same clock domain.
- start, input, 1: request to begin an observation window.
- win_len, input, CNT_W: number of samples in the window, captured when start is accepted.
- busy, output, 1: high while in RUN.
- done, output, 1: results valid; high while in HOLD.
- ack, input, 1: consumer has read the results.
- sig_out, output, SIG_W: MISR signature.
- ones_cnt, output, CNT_W: count of samples with obs_in=1.
- toggle_cnt, output, CNT_W: count of samples that differ from the previous sample.

Function
REQ-006 The FSM SHALL have three states, IDLE, RUN and HOLD, encoded as an enum.
REQ-007 In IDLE, if start=1 and win_len!=0 at edge k, the block SHALL enter RUN and perform these loads:
- remaining <= win_len.
- sig <= SEED.
- ones_cnt <= 0 and toggle_cnt <= 0.
- prev <= 0.
REQ-008 In IDLE, start=1 with win_len=0 SHALL be ignored: the block stays in IDLE and no register changes.
REQ-009 In RUN, the block SHALL sample obs_in once per edge, at edges k+1 through k+N, where N is the captured win_len.
REQ-010 On each sample the MISR SHALL update as sig <= (sig>>1) XOR ((sig[0] XOR obs_in) ? POLY : 0).
REQ-011 On each sample, ones_cnt SHALL increment by obs_in; the width cannot overflow because N <= 2^CNT_W-1.
REQ-012 On each sample, toggle_cnt SHALL increment when obs_in != prev; prev SHALL then take obs_in, so the first sample is compared against 0.
REQ-013 On the sample edge at which remaining==1, the block SHALL enter HOLD; done SHALL be high from that edge on, so latency from start acceptance to done is N+1 edges.
REQ-014 In RUN, start SHALL be ignored, and a change on win_len SHALL not affect the active window.
REQ-015 In HOLD, sig_out, ones_cnt and toggle_cnt SHALL stay stable until ack=1; ack then returns the block to IDLE at that edge, outputs keep their values, and done falls.
REQ-016 In HOLD, start and ack asserted together SHALL apply only ack; the start is dropped and must be re-asserted in IDLE.
REQ-017 ack outside HOLD SHALL be ignored.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==HOLD); both SHALL be driven directly from state registers.

Reset
REQ-019 While I1477_rst=0, asynchronously and regardless of the clock, the block SHALL force:
- state to IDLE.
- busy=0 and done=0.
- sig_out=SEED.
- ones_cnt=0, toggle_cnt=0, remaining=0, prev=0.
REQ-020 Reset asserted mid-RUN or mid-HOLD SHALL abort the window with no partial results retained; after release, the block SHALL need a new start.
REQ-021 Reset deassertion SHALL take effect without a glitch on done or busy.

Structure
REQ-022 Package nt_obs_pkg SHALL hold the state enum and the SIG_W, CNT_W, POLY and SEED defaults.
REQ-023 The MISR SHALL be a sub-module nt_misr with ports clk, rst_n, load, en, din and sig; the top-level holds the FSM and counters.

Verification
REQ-024 Reset, then win_len=1, start, obs_in=0 SHALL give done after 2 edges with sig_out=16'hCBFF, ones_cnt=0, toggle_cnt=0.
REQ-025 win_len=1 with obs_in=1 SHALL give sig_out=16'h7FFF, ones_cnt=1, toggle_cnt=1.
REQ-026 win_len=4 with obs_in sequence 1,0,1,1 SHALL give ones_cnt=3, toggle_cnt=3, done on edge k+4, and busy high for 4 cycles.
REQ-027 start with win_len=0 SHALL leave the block in IDLE with busy=0; start re-pulsed in RUN SHALL leave the count unchanged.
REQ-028 In HOLD, holding ack=0 for 10 cycles SHALL keep outputs stable; start+ack together SHALL return to IDLE with no new window.
REQ-029 Reset asserted mid-RUN at sample 3 of 8 SHALL immediately give done=0, busy=0 and sig_out=16'hFFFF, with no done after release.
